// File: rtl/req_ack_monitor.sv
// Passive per-channel req/ack protocol checker; errors and completions reported one cycle after detection.
// No backpressure: observes only. Define REQ_ACK_MON_DATA_CHECK_EN to compare the data bus at ack against the value captured at req.
module req_ack_monitor #(
   parameter int CHANNELS    = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int MAX_LATENCY = 16,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                           clk,
   input  logic                           reset_l,
   input  logic [CHANNELS-1:0]            req,
   input  logic [CHANNELS-1:0]            ack,
   input  logic [CHANNELS*DATA_WIDTH-1:0] data,
   output logic [CHANNELS-1:0]            outstanding,
   output logic                           err_valid,
   output logic [4:0]                     err_chan,
   output logic [2:0]                     err_code,
   output logic [CHANNELS-1:0]            err_sticky,
   output logic [CNT_WIDTH-1:0]           err_count,
   output logic                           done_valid,
   output logic [4:0]                     done_chan,
   output logic [CNT_WIDTH-1:0]           done_latency
);

   typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

   localparam logic [2:0] CODE_SPURIOUS = 3'd1;
   localparam logic [2:0] CODE_OVERLAP  = 3'd2;
   localparam logic [2:0] CODE_TIMEOUT  = 3'd3;
   localparam logic [2:0] CODE_MISMATCH = 3'd4;
   localparam logic [CNT_WIDTH-1:0] MAX_LAT = CNT_WIDTH'(MAX_LATENCY);
   localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

   state_t               state_q [CHANNELS];
   state_t               state_d [CHANNELS];
   logic [CNT_WIDTH-1:0] timer_q [CHANNELS];
   logic [CNT_WIDTH-1:0] timer_d [CHANNELS];
   logic [2:0]           code    [CHANNELS];
   logic [CHANNELS-1:0]  err_ev;
   logic [CHANNELS-1:0]  done_ev;
   logic [CHANNELS-1:0]  mismatch;

`ifdef REQ_ACK_MON_DATA_CHECK_EN
   logic [DATA_WIDTH-1:0] cap_q [CHANNELS];

   // Every accepted req (fresh, back-to-back or overlapping) recaptures the bus.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         for (int n = 0; n < CHANNELS; n++) cap_q[n] <= '0;
      end else begin
         for (int n = 0; n < CHANNELS; n++)
            if (req[n]) cap_q[n] <= data[n*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      mismatch = '0;
      for (int n = 0; n < CHANNELS; n++)
         mismatch[n] = (data[n*DATA_WIDTH +: DATA_WIDTH] != cap_q[n]);
   end
`else
   logic unused_data;
   assign unused_data = ^data;
   assign mismatch    = '0;
`endif

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         for (int n = 0; n < CHANNELS; n++) begin
            state_q[n] <= IDLE;
            timer_q[n] <= '0;
         end
      end else begin
         for (int n = 0; n < CHANNELS; n++) begin
            state_q[n] <= state_d[n];
            timer_q[n] <= timer_d[n];
         end
      end
   end

   always_comb begin
      err_ev  = '0;
      done_ev = '0;
      for (int n = 0; n < CHANNELS; n++) begin
         state_d[n] = state_q[n];
         timer_d[n] = timer_q[n];
         code[n]    = 3'd0;
         case (state_q[n])
            IDLE: begin
               // Same-cycle ack is an error, but the req is still taken.
               if (ack[n]) begin
                  err_ev[n] = 1'b1;
                  code[n]   = CODE_SPURIOUS;
               end
               if (req[n]) begin
                  state_d[n] = WAIT_ACK;
                  timer_d[n] = ONE;
               end
            end
            WAIT_ACK: begin
               if (ack[n]) begin
                  done_ev[n] = 1'b1;
                  if (mismatch[n]) begin
                     err_ev[n] = 1'b1;
                     code[n]   = CODE_MISMATCH;
                  end
                  if (req[n]) begin
                     timer_d[n] = ONE;
                  end else begin
                     state_d[n] = IDLE;
                     timer_d[n] = '0;
                  end
               end else if (req[n]) begin
                  err_ev[n]  = 1'b1;
                  code[n]    = CODE_OVERLAP;
                  timer_d[n] = ONE;
               end else if (timer_q[n] == MAX_LAT) begin
                  err_ev[n]  = 1'b1;
                  code[n]    = CODE_TIMEOUT;
                  state_d[n] = IDLE;
                  timer_d[n] = '0;
               end else begin
                  timer_d[n] = timer_q[n] + ONE;
               end
            end
            default: state_d[n] = IDLE;
         endcase
      end
   end

   always_comb begin
      outstanding = '0;
      for (int n = 0; n < CHANNELS; n++) outstanding[n] = (state_q[n] == WAIT_ACK);
   end

   logic [4:0]           sel_err_chan;
   logic [2:0]           sel_err_code;
   logic [4:0]           sel_done_chan;
   logic [CNT_WIDTH-1:0] sel_done_lat;
   logic [5:0]           err_pop;
   logic [CNT_WIDTH+5:0] cnt_sum;
   logic [CNT_WIDTH-1:0] cnt_next;

   // Walk downward so the lowest-index active channel wins.
   always_comb begin
      sel_err_chan  = '0;
      sel_err_code  = '0;
      sel_done_chan = '0;
      sel_done_lat  = '0;
      err_pop       = '0;
      for (int n = CHANNELS - 1; n >= 0; n--) begin
         if (err_ev[n]) begin
            sel_err_chan = 5'(n);
            sel_err_code = code[n];
         end
         if (done_ev[n]) begin
            sel_done_chan = 5'(n);
            sel_done_lat  = timer_q[n];
         end
         err_pop = err_pop + 6'(err_ev[n]);
      end
      cnt_sum  = {6'b0, err_count} + {{CNT_WIDTH{1'b0}}, err_pop};
      cnt_next = (cnt_sum > {6'b0, {CNT_WIDTH{1'b1}}}) ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         err_valid    <= 1'b0;
         err_chan     <= '0;
         err_code     <= '0;
         err_sticky   <= '0;
         err_count    <= '0;
         done_valid   <= 1'b0;
         done_chan    <= '0;
         done_latency <= '0;
      end else begin
         err_valid  <= |err_ev;
         err_sticky <= err_sticky | err_ev;
         err_count  <= cnt_next;
         done_valid <= |done_ev;
         if (|err_ev) begin
            err_chan <= sel_err_chan;
            err_code <= sel_err_code;
         end
         if (|done_ev) begin
            done_chan    <= sel_done_chan;
            done_latency <= sel_done_lat;
         end
      end
   end

endmodule

// File: tb/tb_req_ack_monitor.sv
// Scoreboard bench for req_ack_monitor: expected reports queued at drive time, matched by cycle.
module tb_req_ack_monitor;
   localparam int CH = 4;
   localparam int DW = 32;
   localparam int ML = 16;
   localparam int CW = 8;

   logic              clk = 1'b0;
   logic              reset_l = 1'b1;
   logic [CH-1:0]     req = '0;
   logic [CH-1:0]     ack = '0;
   logic [CH*DW-1:0]  data = '0;
   logic [CH-1:0]     outstanding;
   logic              err_valid;
   logic [4:0]        err_chan;
   logic [2:0]        err_code;
   logic [CH-1:0]     err_sticky;
   logic [CW-1:0]     err_count;
   logic              done_valid;
   logic [4:0]        done_chan;
   logic [CW-1:0]     done_latency;

   req_ack_monitor #(.CHANNELS(CH), .DATA_WIDTH(DW), .MAX_LATENCY(ML), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset_l(reset_l), .req(req), .ack(ack), .data(data),
      .outstanding(outstanding), .err_valid(err_valid), .err_chan(err_chan),
      .err_code(err_code), .err_sticky(err_sticky), .err_count(err_count),
      .done_valid(done_valid), .done_chan(done_chan), .done_latency(done_latency));

   always #5 clk = ~clk;

   typedef struct {int cyc; int chan; int val;} ev_t;
   ev_t exp_err[$];
   ev_t exp_done[$];

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   int exp_count = 0;
   logic [CH-1:0] exp_sticky = '0;
   int ei;
   int di;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input logic [CH-1:0] r, input logic [CH-1:0] a);
      req = r;
      ack = a;
      @(negedge clk);
      req = '0;
      ack = '0;
   endtask

   task automatic push_err(input int chan, input int code, input int dly);
      ev_t e;
      e.cyc = cyc + dly; e.chan = chan; e.val = code;
      exp_err.push_back(e);
      exp_sticky[chan] = 1'b1;
      exp_count = (exp_count + 1 > 255) ? 255 : exp_count + 1;
   endtask

   task automatic push_done(input int chan, input int lat);
      ev_t e;
      e.cyc = cyc + 1; e.chan = chan; e.val = lat;
      exp_done.push_back(e);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         ei = -1;
         foreach (exp_err[i]) if (ei < 0 && exp_err[i].cyc == cyc) ei = i;
         if (ei >= 0) begin
            check("err_valid", 32'(err_valid), 32'd1);
            check("err_chan", 32'(err_chan), 32'(exp_err[ei].chan));
            check("err_code", 32'(err_code), 32'(exp_err[ei].val));
            exp_err.delete(ei);
         end else if (err_valid) begin
            check("err_unexpected", 32'(err_valid), 32'd0);
         end
         di = -1;
         foreach (exp_done[i]) if (di < 0 && exp_done[i].cyc == cyc) di = i;
         if (di >= 0) begin
            check("done_valid", 32'(done_valid), 32'd1);
            check("done_chan", 32'(done_chan), 32'(exp_done[di].chan));
            check("done_latency", 32'(done_latency), 32'(exp_done[di].val));
            exp_done.delete(di);
         end else if (done_valid) begin
            check("done_unexpected", 32'(done_valid), 32'd0);
         end
      end
   end

   task automatic check_counters(input string tag);
      check({tag, "_sticky"}, 32'(err_sticky), 32'(exp_sticky));
      check({tag, "_count"}, 32'(err_count), 32'(exp_count));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outstanding"}, 32'(outstanding), 32'd0);
      check({tag, "_err_valid"}, 32'(err_valid), 32'd0);
      check({tag, "_err_chan_code"}, {24'd0, err_chan, err_code}, 32'd0);
      check({tag, "_err_sticky"}, 32'(err_sticky), 32'd0);
      check({tag, "_err_count"}, 32'(err_count), 32'd0);
      check({tag, "_done_valid"}, 32'(done_valid), 32'd0);
      check({tag, "_done_chan_lat"}, {19'd0, done_chan, done_latency}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 reset_l = 1'b0;
      #1 check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      reset_l = 1'b1;
      mon_en  = 1'b1;
      repeat (2) @(negedge clk);

      // ch0 req with 2-cycle latency
      data[0 +: DW] = 32'hfeed;
      step(4'b0001, 4'b0000);
      check("ch0_outst_a", 32'(outstanding), 32'h1);
      step(4'b0000, 4'b0000);
      check("ch0_outst_b", 32'(outstanding), 32'h1);
      push_done(0, 2);
      step(4'b0000, 4'b0001);
      check("ch0_outst_c", 32'(outstanding), 32'h0);

      // spurious ack on ch2
      push_err(2, 1, 1);
      step(4'b0000, 4'b0100);
      check_counters("spur2");

      // ch1 timeout
      push_err(1, 3, ML + 1);
      step(4'b0010, 4'b0000);
      repeat (ML + 2) step(4'b0000, 4'b0000);
      check("timeout_outst", 32'(outstanding), 32'h0);
      check_counters("timeout");

      // ch1 ack at the latest legal cycle
      step(4'b0010, 4'b0000);
      repeat (ML - 1) step(4'b0000, 4'b0000);
      push_done(1, ML);
      step(4'b0000, 4'b0010);
      repeat (3) step(4'b0000, 4'b0000);

      // ch3 overlapping req, then ack
      step(4'b1000, 4'b0000);
      repeat (2) step(4'b0000, 4'b0000);
      push_err(3, 2, 1);
      step(4'b1000, 4'b0000);
      step(4'b0000, 4'b0000);
      push_done(3, 2);
      step(4'b0000, 4'b1000);
      check_counters("overlap");

      // simultaneous spurious acks on ch1 and ch3
      push_err(1, 1, 1);
      exp_sticky[3] = 1'b1;
      exp_count = exp_count + 1;
      step(4'b0000, 4'b1010);
      check_counters("dual_spur");

      // simultaneous completions on ch0 and ch2: ch0 reported
      step(4'b0101, 4'b0000);
      push_done(0, 1);
      step(4'b0000, 4'b0101);
      check("dual_done_outst", 32'(outstanding), 32'h0);

      // data changed between req and ack on ch0
      data[0 +: DW] = 32'h1234;
      step(4'b0001, 4'b0000);
      data[0 +: DW] = 32'h1235;
      push_done(0, 1);
`ifdef REQ_ACK_MON_DATA_CHECK_EN
      push_err(0, 4, 1);
`endif
      step(4'b0000, 4'b0001);
      check_counters("data_chk");

      // saturation: 260 spurious acks
      for (int i = 0; i < 65; i++) begin
         push_err(0, 1, 1);
         exp_sticky = 4'b1111;
         exp_count  = (exp_count + 3 > 255) ? 255 : exp_count + 3;
         step(4'b0000, 4'b1111);
      end
      check_counters("saturate");

      // reset in the middle of a transaction
      step(4'b0100, 4'b0000);
      step(4'b0000, 4'b0000);
      check("pre_reset_outst", 32'(outstanding), 32'h4);
      reset_l = 1'b0;
      #1 check_all_zero("mid_reset");
      @(negedge clk);
      reset_l   = 1'b1;
      exp_sticky = '0;
      exp_count  = 0;
      push_err(2, 1, 1);
      step(4'b0000, 4'b0100);
      check_counters("post_reset");

      repeat (4) @(negedge clk);
      check("err_queue_left", 32'(exp_err.size()), 32'd0);
      check("done_queue_left", 32'(exp_done.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/req_ack_monitor.md
Name: req_ack_monitor

Overview:
Synthesizable multi-channel protocol monitor for single-cycle-pulse request/acknowledge handshakes. It tracks CHANNELS independent req/ack pairs and reports protocol violations: spurious ack, overlapping req and ack timeout. It also reports completion latency. It sits passively beside bus interfaces, in both simulation benches and emulation builds, and replaces per-call PLI handshake assertions with a hardware checker that has error reporting and counters.

Parameters:
CHANNELS, 4, number of independent req/ack channels (1..32)
DATA_WIDTH, 32, width of per-channel data bus captured at req
MAX_LATENCY, 16, max cycles from req to ack (>=1)
CNT_WIDTH, 8, width of saturating error counter and latency outputs; must hold MAX_LATENCY

Ports:
clk  in  1  clock, all logic on rising edge
reset_l  in  1  asynchronous active-low reset
req  in  CHANNELS  per-channel request pulse
ack  in  CHANNELS  per-channel acknowledge pulse
data  in  CHANNELS*DATA_WIDTH  per-channel data; channel n at [n*DATA_WIDTH +: DATA_WIDTH]
outstanding  out  CHANNELS  channel n is in WAIT_ACK
err_valid  out  1  one-cycle error report pulse
err_chan  out  5  channel of reported error
err_code  out  3  1=SPURIOUS_ACK 2=OVERLAP_REQ 3=TIMEOUT 4=DATA_MISMATCH
err_sticky  out  CHANNELS  per-channel error-seen flags; cleared only by reset
err_count  out  CNT_WIDTH  total error events, saturating
done_valid  out  1  one-cycle completion pulse
done_chan  out  5  channel that completed
done_latency  out  CNT_WIDTH  cycles from req to ack (1..MAX_LATENCY)

Behaviour:
- Reset (reset_l low, asynchronous): all channels go to IDLE; timers=0; every output=0.
- Per-channel FSM, states IDLE and WAIT_ACK. Per-channel timer is CNT_WIDTH bits wide. Per-channel data capture register is DATA_WIDTH bits wide.
- IDLE, req=1, ack=0: capture data, timer<=1, go to WAIT_ACK.
- IDLE, ack=1: SPURIOUS_ACK, whatever req is. Ack in the same cycle as req is never valid; minimum latency is 1. If req=1 in that same cycle, the request is still accepted as above.
- IDLE, both 0: hold.
- WAIT_ACK, ack=1: complete. Done event with latency=timer. If req=1 in the same cycle (back-to-back), recapture data, timer<=1, stay in WAIT_ACK. Otherwise go to IDLE.
- WAIT_ACK, req=1, ack=0: OVERLAP_REQ. Recapture data, timer<=1, stay in WAIT_ACK (the new request supersedes the old one).
- WAIT_ACK, neither, timer==MAX_LATENCY: TIMEOUT, go to IDLE, timer<=0.
- WAIT_ACK, neither, otherwise: timer<=timer+1.
- Timeline for req in cycle t: ack is legal in t+1..t+MAX_LATENCY. Without ack, TIMEOUT is detected in cycle t+MAX_LATENCY and reported in t+MAX_LATENCY+1.
- Outputs are registered with one cycle of latency: an event detected in cycle c gives err_valid/done_valid high in cycle c+1. outstanding reflects the current state.
- At most one error event per channel per cycle.
- Simultaneous errors on several channels: err_chan/err_code report the lowest-index channel. err_sticky sets bits for all erroring channels. err_count adds the number of erroring channels (popcount) and saturates at all-ones.
- Simultaneous completions: lowest-index channel reported on done_*; others are dropped from done_* but still change state.
- err_chan/err_code/done_chan/done_latency hold their last value when the corresponding valid is low.
- Reset mid-transaction: the channel returns to IDLE. An ack after reset is SPURIOUS_ACK.

Optional Feature:
REQ_ACK_MON_DATA_CHECK_EN:
- Defined: in WAIT_ACK with ack=1, the data bus is compared to the captured value. On mismatch, DATA_MISMATCH is reported instead of a silent completion. The done event still fires and the state transition is unchanged. The mismatch is counted in err_count/err_sticky.
- Undefined: no comparator; code 4 is never produced; captured data registers may be optimised away.

Test Plan:
- CHANNELS=4, MAX_LATENCY=16. Ch0 req pulse at cycle 10 with data=32'hfeed, ack at cycle 12 -> done_valid at 13, done_chan=0, done_latency=2, no err_valid, outstanding[0] high cycles 11-12.
- Ch2 ack with no prior req -> err_valid one cycle later, err_chan=2, err_code=1, err_sticky=4'b0100, err_count=1.
- Ch1 req at cycle 5, no ack -> err_valid at cycle 22, err_code=3, err_chan=1. Ack at cycle 21 instead -> done_latency=16, no error.
- Ch3 req at t, req at t+3 (no ack) -> err_code=2 at t+4. Ack at t+5 -> done_latency=2.
- Ch1 and ch3 spurious ack in the same cycle -> err_chan=1, err_sticky=4'b1010, err_count+=2. Saturation: 260 errors with CNT_WIDTH=8 -> err_count=255.
- With REQ_ACK_MON_DATA_CHECK_EN: ch0 req with data=32'h1234, data changed to 32'h1235 at ack -> err_code=4 and done_valid both asserted. Without the macro -> done only. Reset_l pulled low in WAIT_ACK -> outstanding=0 immediately, all outputs 0.
